// File: rtl/video_timing_pkg.sv
// Shared raster-timing constants for the HDMI pipeline: 720p60 defaults, counter widths and
// the helper that derives line/frame totals from the four timing spans.
package video_timing_pkg;

  localparam int unsigned HActive720     = 1280;
  localparam int unsigned HFrontPorch720 = 110;
  localparam int unsigned HSyncWidth720  = 40;
  localparam int unsigned HBackPorch720  = 220;

  localparam int unsigned VActive720     = 720;
  localparam int unsigned VFrontPorch720 = 5;
  localparam int unsigned VSyncWidth720  = 5;
  localparam int unsigned VBackPorch720  = 20;

  localparam int unsigned Fps720         = 60;

  localparam int unsigned HCountW = 11;
  localparam int unsigned VCountW = 10;
  localparam int unsigned FcW     = 6;

  // Every position compare/sum is done at this width so porch arithmetic cannot wrap.
  localparam int unsigned CmpW = 12;
  typedef logic [CmpW-1:0] cmp_t;

  function automatic int unsigned span_total(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return active + front + sync + back;
  endfunction

  localparam int unsigned TotalPixels720 =
    span_total(HActive720, HFrontPorch720, HSyncWidth720, HBackPorch720);
  localparam int unsigned TotalLines720 =
    span_total(VActive720, VFrontPorch720, VSyncWidth720, VBackPorch720);

endpackage

// File: rtl/video_sig_gen.sv
// Raster position counter and sync/blank decoder. Flags are decoded from the next position
// and registered alongside the counters, so they always describe the position shown.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H_PIXELS = HActive720,
  parameter int unsigned H_FRONT_PORCH   = HFrontPorch720,
  parameter int unsigned H_SYNC_WIDTH    = HSyncWidth720,
  parameter int unsigned H_BACK_PORCH    = HBackPorch720,
  parameter int unsigned ACTIVE_LINES    = VActive720,
  parameter int unsigned V_FRONT_PORCH   = VFrontPorch720,
  parameter int unsigned V_SYNC_WIDTH    = VSyncWidth720,
  parameter int unsigned V_BACK_PORCH    = VBackPorch720,
  parameter int unsigned FPS             = Fps720
) (
  input  logic               clk_in,
  input  logic               rst_in,
  output logic [HCountW-1:0] hcount_out,
  output logic [VCountW-1:0] vcount_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic               ad_out,
  output logic               nf_out,
  output logic [FcW-1:0]     fc_out
);

  localparam int unsigned TOTAL_PIXELS =
    span_total(ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH);
  localparam int unsigned TOTAL_LINES =
    span_total(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH);

  if (TOTAL_PIXELS > (1 << HCountW) || TOTAL_LINES > (1 << VCountW) ||
      FPS == 0 || FPS > (1 << FcW)) begin : g_bad_timing
    $error("video_sig_gen: timing totals or FPS do not fit the counter widths");
  end

  localparam cmp_t HLast      = cmp_t'(TOTAL_PIXELS - 1);
  localparam cmp_t VLast      = cmp_t'(TOTAL_LINES - 1);
  localparam cmp_t HActive    = cmp_t'(ACTIVE_H_PIXELS);
  localparam cmp_t VActive    = cmp_t'(ACTIVE_LINES);
  localparam cmp_t HSyncStart = cmp_t'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam cmp_t HSyncEnd   = cmp_t'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam cmp_t VSyncStart = cmp_t'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam cmp_t VSyncEnd   = cmp_t'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [FcW-1:0] FcLast = FcW'(FPS - 1);

  logic [HCountW-1:0] hcount_q;
  logic [VCountW-1:0] vcount_q;
  logic               hs_q, vs_q, ad_q, nf_q;
  logic [FcW-1:0]     fc_q;

  cmp_t           h_cur, v_cur, h_d, v_d;
  logic           hs_d, vs_d, ad_d, nf_d;
  logic [FcW-1:0] fc_d;

  always_comb begin
    h_cur = cmp_t'(hcount_q);
    v_cur = cmp_t'(vcount_q);
    h_d   = h_cur + cmp_t'(1);
    v_d   = v_cur;
    if (h_cur == HLast) begin
      h_d = '0;
      v_d = (v_cur == VLast) ? '0 : v_cur + cmp_t'(1);
    end

    ad_d = (h_d < HActive) && (v_d < VActive);
    hs_d = (h_d >= HSyncStart) && (h_d < HSyncEnd);
    vs_d = (v_d >= VSyncStart) && (v_d < VSyncEnd);
    nf_d = (h_d == HActive) && (v_d == VActive);

    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FcLast) ? '0 : fc_q + FcW'(1);
    end
  end

  // Reset parks the counters on the last pixel so the first free-running edge lands on (0,0).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hcount_q <= HLast[HCountW-1:0];
      vcount_q <= VLast[VCountW-1:0];
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
      fc_q     <= '0;
    end else begin
      hcount_q <= h_d[HCountW-1:0];
      vcount_q <= v_d[VCountW-1:0];
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
      fc_q     <= fc_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: default 720p, 640x480 and a tiny raster run side by side against a
// position-from-cycle-index reference model, plus tabled corner points and mid-frame resets.
`timescale 1ns/1ps
module tb_video_sig_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } vid_t;

  typedef struct {
    int     inst;
    longint t;
    vid_t   exp;
  } vec_t;

  // Per instance: HA HFP HSW HBP VA VFP VSW VBP FPS
  int unsigned prm [3][9] = '{'{1280, 110, 40, 220, 720, 5, 5, 20, 60},
                              '{640, 16, 96, 48, 480, 10, 2, 33, 60},
                              '{8, 2, 3, 2, 4, 1, 2, 1, 60}};

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [10:0] hc_w [3];
  logic [9:0]  vc_w [3];
  logic        hs_w [3];
  logic        vs_w [3];
  logic        ad_w [3];
  logic        nf_w [3];
  logic [5:0]  fc_w [3];

  always #5 clk = ~clk;

  video_sig_gen u_dflt (
    .clk_in(clk), .rst_in(rst[0]), .hcount_out(hc_w[0]), .vcount_out(vc_w[0]),
    .hs_out(hs_w[0]), .vs_out(vs_w[0]), .ad_out(ad_w[0]), .nf_out(nf_w[0]), .fc_out(fc_w[0])
  );

  video_sig_gen #(
    .ACTIVE_H_PIXELS(640), .H_FRONT_PORCH(16), .H_SYNC_WIDTH(96), .H_BACK_PORCH(48),
    .ACTIVE_LINES(480), .V_FRONT_PORCH(10), .V_SYNC_WIDTH(2), .V_BACK_PORCH(33), .FPS(60)
  ) u_vga (
    .clk_in(clk), .rst_in(rst[1]), .hcount_out(hc_w[1]), .vcount_out(vc_w[1]),
    .hs_out(hs_w[1]), .vs_out(vs_w[1]), .ad_out(ad_w[1]), .nf_out(nf_w[1]), .fc_out(fc_w[1])
  );

  video_sig_gen #(
    .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(2),
    .ACTIVE_LINES(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1), .FPS(60)
  ) u_tiny (
    .clk_in(clk), .rst_in(rst[2]), .hcount_out(hc_w[2]), .vcount_out(vc_w[2]),
    .hs_out(hs_w[2]), .vs_out(vs_w[2]), .ad_out(ad_w[2]), .nf_out(nf_w[2]), .fc_out(fc_w[2])
  );

  int errors = 0;
  int checks = 0;

  // Cycles since the first free-running edge; -1 means the last edge saw reset.
  longint tc [3] = '{-1, -1, -1};
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) tc[i] <= rst[i] ? -64'sd1 : tc[i] + 1;
  end

  function automatic vid_t get_act(input int i);
    vid_t r;
    r.h = hc_w[i]; r.v = vc_w[i]; r.hs = hs_w[i]; r.vs = vs_w[i];
    r.ad = ad_w[i]; r.nf = nf_w[i]; r.fc = fc_w[i];
    return r;
  endfunction

  function automatic vid_t mk(input int h, input int v, input bit hs, input bit vs,
                              input bit ad, input bit nf, input int fc);
    vid_t r;
    r.h = 11'(h); r.v = 10'(v); r.hs = hs; r.vs = vs; r.ad = ad; r.nf = nf; r.fc = 6'(fc);
    return r;
  endfunction

  // Position is a pure function of elapsed cycles; fc counts new-frame points passed.
  function automatic vid_t ref_model(input int i, input longint t);
    longint ha = prm[i][0], hf = prm[i][1], hw = prm[i][2], hb = prm[i][3];
    longint va = prm[i][4], vf = prm[i][5], vw = prm[i][6], vb = prm[i][7];
    longint fps = prm[i][8];
    longint ht = ha + hf + hw + hb;
    longint vt = va + vf + vw + vb;
    longint nf0 = va * ht + ha;
    longint h, v;
    vid_t r = '0;
    if (t < 0) begin
      r.h = 11'(ht - 1);
      r.v = 10'(vt - 1);
      return r;
    end
    h = t % ht;
    v = (t / ht) % vt;
    r.h  = 11'(h);
    r.v  = 10'(v);
    r.ad = (h < ha) && (v < va);
    r.hs = (h >= ha + hf) && (h < ha + hf + hw);
    r.vs = (v >= va + vf) && (v < va + vf + vw);
    r.nf = (h == ha) && (v == va);
    if (t >= nf0) r.fc = 6'((((t - nf0) / (ht * vt)) + 1) % fps);
    return r;
  endfunction

  function automatic bit check(input string name, input int i, input vid_t a, input vid_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s inst%0d t=%0d: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
               name, i, tc[i], a.h, a.v, a.hs, a.vs, a.ad, a.nf, a.fc,
               e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void timeout(input string name, input int i);
    checks++;
    errors++;
    $display("FAIL %s inst%0d: wait budget expired at t=%0d, want target position reached",
             name, i, tc[i]);
  endfunction

  // Every-cycle comparison against the model, capped per instance to keep logs short.
  bit cyc_en = 1'b0;
  int cyc_err [3] = '{0, 0, 0};
  always @(negedge clk) begin
    if (cyc_en) begin
      for (int i = 0; i < 3; i++) begin
        if (cyc_err[i] < 8) begin
          if (!check("cycle", i, get_act(i), ref_model(i, tc[i]))) cyc_err[i]++;
        end
      end
    end
  end

  task automatic mid_reset(input string name, input int i, input longint pos, input longint md,
                           input bit hs_pre, input bit vs_pre, input vid_t rexp);
    int budget = 5000;
    vid_t pre;
    while ((tc[i] < 0 || (tc[i] % md) != pos) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      timeout(name, i);
      return;
    end
    pre = get_act(i);
    checks++;
    if (pre.hs !== hs_pre || pre.vs !== vs_pre) begin
      errors++;
      $display("FAIL %s_pre inst%0d: got hs=%b vs=%b, want hs=%b vs=%b",
               name, i, pre.hs, pre.vs, hs_pre, vs_pre);
    end
    rst[i] = 1'b1;
    @(negedge clk);
    void'(check({name, "_rst"}, i, get_act(i), rexp));
    rst[i] = 1'b0;
    @(negedge clk);
    void'(check({name, "_rel"}, i, get_act(i), mk(0, 0, 0, 0, 1, 0, 0)));
  endtask

  vec_t vecs [$];

  function automatic void add(input int inst, input longint t, input vid_t e);
    vec_t r;
    r.inst = inst; r.t = t; r.exp = e;
    vecs.push_back(r);
  endfunction

  initial begin
    // Hand-derived corner points, sorted by cycle index (all instances leave reset together).
    add(0, 0,    mk(0, 0, 0, 0, 1, 0, 0));
    add(2, 0,    mk(0, 0, 0, 0, 1, 0, 0));
    add(2, 8,    mk(8, 0, 0, 0, 0, 0, 0));
    add(2, 10,   mk(10, 0, 1, 0, 0, 0, 0));
    add(2, 12,   mk(12, 0, 1, 0, 0, 0, 0));
    add(2, 13,   mk(13, 0, 0, 0, 0, 0, 0));
    add(2, 14,   mk(14, 0, 0, 0, 0, 0, 0));
    add(2, 15,   mk(0, 1, 0, 0, 1, 0, 0));
    add(2, 68,   mk(8, 4, 0, 0, 0, 1, 1));
    add(2, 69,   mk(9, 4, 0, 0, 0, 0, 1));
    add(2, 75,   mk(0, 5, 0, 1, 0, 0, 1));
    add(2, 104,  mk(14, 6, 0, 1, 0, 0, 1));
    add(2, 105,  mk(0, 7, 0, 0, 0, 0, 1));
    add(2, 119,  mk(14, 7, 0, 0, 0, 0, 1));
    add(2, 120,  mk(0, 0, 0, 0, 1, 0, 1));
    add(2, 188,  mk(8, 4, 0, 0, 0, 1, 2));
    add(1, 639,  mk(639, 0, 0, 0, 1, 0, 0));
    add(1, 640,  mk(640, 0, 0, 0, 0, 0, 0));
    add(1, 655,  mk(655, 0, 0, 0, 0, 0, 0));
    add(1, 656,  mk(656, 0, 1, 0, 0, 0, 0));
    add(1, 751,  mk(751, 0, 1, 0, 0, 0, 0));
    add(1, 752,  mk(752, 0, 0, 0, 0, 0, 0));
    add(1, 799,  mk(799, 0, 0, 0, 0, 0, 0));
    add(1, 800,  mk(0, 1, 0, 0, 1, 0, 0));
    add(0, 1279, mk(1279, 0, 0, 0, 1, 0, 0));
    add(0, 1280, mk(1280, 0, 0, 0, 0, 0, 0));
    add(0, 1389, mk(1389, 0, 0, 0, 0, 0, 0));
    add(0, 1390, mk(1390, 0, 1, 0, 0, 0, 0));
    add(0, 1429, mk(1429, 0, 1, 0, 0, 0, 0));
    add(0, 1430, mk(1430, 0, 0, 0, 0, 0, 0));
    add(0, 1649, mk(1649, 0, 0, 0, 0, 0, 0));
    add(0, 1650, mk(0, 1, 0, 0, 1, 0, 0));
    add(2, 7028, mk(8, 4, 0, 0, 0, 1, 59));
    add(2, 7148, mk(8, 4, 0, 0, 0, 1, 0));

    rst = 3'b111;
    repeat (3) @(negedge clk);
    cyc_en = 1'b1;
    void'(check("reset_dflt", 0, get_act(0), mk(1649, 749, 0, 0, 0, 0, 0)));
    void'(check("reset_vga", 1, get_act(1), mk(799, 524, 0, 0, 0, 0, 0)));
    void'(check("reset_tiny", 2, get_act(2), mk(14, 7, 0, 0, 0, 0, 0)));
    rst = 3'b000;

    for (int k = 0; k < vecs.size(); k++) begin
      int budget = 10000;
      while (tc[vecs[k].inst] < vecs[k].t && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (tc[vecs[k].inst] != vecs[k].t) timeout($sformatf("vec%0d", k), vecs[k].inst);
      else void'(check($sformatf("vec%0d", k), vecs[k].inst, get_act(vecs[k].inst),
                       vecs[k].exp));
    end

    // Reset asserted inside hsync (and vsync for the tiny raster) must kill both cleanly.
    mid_reset("midrst_tiny", 2, 86, 120, 1'b1, 1'b1, mk(14, 7, 0, 0, 0, 0, 0));
    mid_reset("midrst_dflt", 0, 1400, 1650, 1'b1, 1'b0, mk(1649, 749, 0, 0, 0, 0, 0));

    // Random reset pulses on random instances; the per-cycle model tracks the restarts.
    for (int n = 0; n < 40; n++) begin
      int i = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 400)) @(negedge clk);
      rst[i] = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst[i] = 1'b0;
    end
    repeat (200) @(negedge clk);
    cyc_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
